// File: rtl/pix_burst_pkg.sv
// pix_burst_pkg -- shared definitions for the pixel burst writer.
//   ADDR_W            : frame-buffer word address width
//   DEF_*             : default parameter values for pix_burst_wr
//   burst_state_e     : burst FSM encoding (IDLE/REQ/DATA)
//   next_burst_addr() : post-burst address advance with frame wrap
package pix_burst_pkg;

    localparam int unsigned ADDR_W = 24;

    localparam int unsigned            DEF_BURST_LEN   = 8;
    localparam int unsigned            DEF_FIFO_DEPTH  = 32;
    localparam int unsigned            DEF_FRAME_WORDS = 192000;
    localparam logic [ADDR_W-1:0]      DEF_BASE_ADDR   = 24'h000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } burst_state_e;

    // Advance by one burst; wrap to base when the burst just written was
    // the last one of the frame.
    function automatic logic [ADDR_W-1:0] next_burst_addr(
        input logic [ADDR_W-1:0] cur,
        input logic [ADDR_W-1:0] step,
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] end_addr
    );
        logic [ADDR_W-1:0] nxt;
        nxt = cur + step;
        return (nxt == end_addr) ? base : nxt;
    endfunction

endpackage

// File: rtl/pix_burst_fifo.sv
// pix_burst_fifo -- synchronous first-word-fall-through FIFO.
//   clk_i, rst_i   : clock, synchronous active-high reset (empties FIFO)
//   push_i, data_i : write strobe and word (ignored when full)
//   pop_i          : read strobe (ignored when empty)
//   data_o         : current head word, valid whenever empty_o is low
//   count_o        : words held; full_o / empty_o status flags
module pix_burst_fifo #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned       AW       = $clog2(DEPTH);
    localparam logic [AW:0]       FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pix_burst_wr.sv
// pix_burst_wr -- packs RGB565 pixel pairs into 32-bit words, buffers them
// in a FWFT FIFO and writes them to a frame buffer in fixed-length bursts.
//   ov5640_pclk, s_rst        : pixel clock, synchronous active-high reset
//   pix_vld/pix_data/pix_x/y  : cropped pixel stream; x==y==0 marks frame start
//   wr_req/wr_ack/wr_addr     : burst request handshake and start word address
//   wr_rdy/wr_data            : per-word data handshake during a burst
//   ovf                       : sticky FIFO overflow, cleared on frame start
// Optional macro PIX_BURST_STAT_EN adds frame_cnt and drop_cnt outputs.
module pix_burst_wr
    import pix_burst_pkg::*;
#(
    parameter int unsigned       BURST_LEN   = DEF_BURST_LEN,
    parameter int unsigned       FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned       FRAME_WORDS = DEF_FRAME_WORDS,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic              ov5640_pclk,
    input  logic              s_rst,
    input  logic              pix_vld,
    input  logic [15:0]       pix_data,
    input  logic [11:0]       pix_x,
    input  logic [11:0]       pix_y,
    output logic              wr_req,
    input  logic              wr_ack,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_rdy,
    output logic [31:0]       wr_data,
    output logic              ovf
`ifdef PIX_BURST_STAT_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int unsigned       CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned       BEAT_W   = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] END_ADDR = BASE_ADDR + ADDR_W'(FRAME_WORDS);

    logic sof;
    assign sof = pix_vld & (pix_x == '0) & (pix_y == '0);

    // ---------------- pixel pair packer ----------------
    logic        phase_q;
    logic [15:0] half_q;
    logic [31:0] word_q;
    logic        push_q;

    always_ff @(posedge ov5640_pclk) begin
        if (s_rst) begin
            phase_q <= 1'b0;
            half_q  <= '0;
            word_q  <= '0;
            push_q  <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (pix_vld) begin
                // A frame start always opens a new pair, dropping any half-word.
                if (sof || !phase_q) begin
                    half_q  <= pix_data;
                    phase_q <= 1'b1;
                end else begin
                    word_q  <= {half_q, pix_data};
                    push_q  <= 1'b1;
                    phase_q <= 1'b0;
                end
            end
        end
    end

    // ---------------- word FIFO ----------------
    logic [31:0]      fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;

    assign drop = push_q & fifo_full;

    pix_burst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i   (ov5640_pclk),
        .rst_i   (s_rst),
        .push_i  (push_q),
        .data_i  (word_q),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ---------------- burst FSM ----------------
    burst_state_e      state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sof_pend_q, sof_pend_d;

    always_ff @(posedge ov5640_pclk) begin
        if (s_rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            addr_q     <= BASE_ADDR;
            sof_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
            sof_pend_q <= sof_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        addr_d     = addr_q;
        sof_pend_d = sof_pend_q | sof;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_count >= CNT_W'(BURST_LEN)) begin
                    state_d = REQ;
                    // Frame restart is applied only between bursts so an
                    // in-flight burst keeps its address; a sof arriving in
                    // this very cycle stays pending for the next burst.
                    if (sof_pend_q) begin
                        addr_d = BASE_ADDR;
                    end
                    sof_pend_d = sof;
                end
            end
            REQ: begin
                if (wr_ack) begin
                    state_d = DATA;
                    beat_d  = '0;
                end
            end
            DATA: begin
                if (wr_rdy && !fifo_empty) begin
                    pop    = 1'b1;
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BT) begin
                        state_d = IDLE;
                        addr_d  = next_burst_addr(addr_q, STEP, BASE_ADDR, END_ADDR);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_req  = (state_q == REQ);
    assign wr_addr = addr_q;
    assign wr_data = (state_q == DATA) ? fifo_head : '0;

    // ---------------- overflow flag ----------------
    logic ovf_q;

    always_ff @(posedge ov5640_pclk) begin
        if (s_rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (sof) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf = ovf_q;

`ifdef PIX_BURST_STAT_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge ov5640_pclk) begin
        if (s_rst) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (sof) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (sof) begin
                drop_cnt_q <= drop ? 16'd1 : '0;
            end else if (drop && drop_cnt_q != '1) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pix_burst_wr.sv
// tb_pix_burst_wr -- scoreboard bench for pix_burst_wr.
// Stimulus pushes expected words/addresses into queues; a negedge monitor
// plays the memory side (wr_ack / wr_rdy) and pops and compares.
// DUT: BURST_LEN=8, FIFO_DEPTH=32, FRAME_WORDS=32 (4 bursts/frame), BASE=0x100.
module tb_pix_burst_wr;

    localparam logic [23:0] BASE = 24'h000100;

    logic        clk = 1'b0;
    logic        s_rst;
    logic        pix_vld;
    logic [15:0] pix_data;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        wr_req;
    logic        wr_ack;
    logic [23:0] wr_addr;
    logic        wr_rdy;
    logic [31:0] wr_data;
    logic        ovf;
`ifdef PIX_BURST_STAT_EN
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    pix_burst_wr #(
        .BURST_LEN   (8),
        .FIFO_DEPTH  (32),
        .FRAME_WORDS (32),
        .BASE_ADDR   (BASE)
    ) dut (
        .ov5640_pclk (clk),
        .s_rst       (s_rst),
        .pix_vld     (pix_vld),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .wr_req      (wr_req),
        .wr_ack      (wr_ack),
        .wr_addr     (wr_addr),
        .wr_rdy      (wr_rdy),
        .wr_data     (wr_data),
        .ovf         (ovf)
`ifdef PIX_BURST_STAT_EN
        ,
        .frame_cnt   (frame_cnt),
        .drop_cnt    (drop_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_data [$];
    logic [23:0] exp_addr [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory-side responder + monitor ----------------
    typedef enum {M_IDLE, M_REQ, M_DATA} mstate_t;
    mstate_t     mst = M_IDLE;
    int          ack_delay = 0;
    bit          rdy_toggle = 0;
    bit          rdy_low = 0;
    int          abort_after = 0;
    bit          abort_hit = 0;
    int          req_cnt = 0;
    int          beats = 0;
    bit          tog = 0;
    logic [23:0] cur_addr = '0;

    task automatic drive_data();
        check("addr_stable_data", wr_addr, cur_addr);
        if (abort_after != 0 && beats == abort_after) begin
            wr_rdy    = 1'b0;
            abort_hit = 1'b1;
        end else begin
            wr_rdy = rdy_low ? 1'b0 : (rdy_toggle ? ~tog : 1'b1);
            tog    = ~tog;
            if (wr_rdy) begin
                if (exp_data.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL burst_data: got %h with no word outstanding, expected none", wr_data);
                end else begin
                    check("burst_data", wr_data, exp_data.pop_front());
                end
                beats++;
                if (beats == 8) mst = M_IDLE;
            end
        end
    endtask

    initial begin
        wr_ack = 1'b0;
        wr_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (s_rst) begin
                mst    = M_IDLE;
                wr_ack = 1'b0;
                wr_rdy = 1'b0;
            end else begin
                case (mst)
                    M_IDLE: begin
                        wr_rdy = 1'b0;
                        if (wr_req) begin
                            if (exp_addr.size() == 0) begin
                                n_vec++;
                                n_err++;
                                $display("FAIL unexpected_burst: wr_req=1 addr %h, expected no request", wr_addr);
                            end else begin
                                check("burst_addr", wr_addr, exp_addr.pop_front());
                            end
                            cur_addr = wr_addr;
                            mst      = M_REQ;
                            req_cnt  = 1;
                            wr_ack   = (ack_delay == 0);
                        end
                    end
                    M_REQ: begin
                        if (wr_ack) begin
                            wr_ack = 1'b0;
                            check("req_drop", wr_req, 0);
                            check("req_len", req_cnt, ack_delay + 1);
                            mst   = M_DATA;
                            beats = 0;
                            tog   = 1'b0;
                            drive_data();
                        end else begin
                            check("req_hold", wr_req, 1);
                            check("addr_stable_req", wr_addr, cur_addr);
                            req_cnt++;
                            if (req_cnt == ack_delay + 1) wr_ack = 1'b1;
                        end
                    end
                    M_DATA: drive_data();
                    default: mst = M_IDLE;
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] half = '0;
    bit          hv = 0;
    int          budget = -1;
    logic [15:0] pv = 16'h0100;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [15:0] d, input bit s);
        pix_vld  = 1'b1;
        pix_data = d;
        pix_x    = s ? 12'd0 : 12'd5;
        pix_y    = s ? 12'd0 : 12'd3;
        if (s || !hv) begin
            half = d;
            hv   = 1'b1;
        end else begin
            hv = 1'b0;
            if (budget != 0) begin
                exp_data.push_back({half, d});
                if (budget > 0) budget--;
            end
        end
        tick();
        pix_vld = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            pix(pv, 1'b0);
            pv = pv + 16'h0101;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_data.size() != 0 || exp_addr.size() != 0 || mst != M_IDLE) && t < 3000) begin
            tick();
            t++;
        end
        check("drain_done", (t < 3000), 1);
    endtask

    initial begin
        int t;
        s_rst    = 1'b1;
        pix_vld  = 1'b0;
        pix_data = '0;
        pix_x    = '0;
        pix_y    = '0;
        repeat (3) tick();
        check("rst_wr_req", wr_req, 0);
        check("rst_wr_addr", wr_addr, BASE);
        check("rst_wr_data", wr_data, 0);
        check("rst_ovf", ovf, 0);
        s_rst = 1'b0;
        tick();

        // basic pair packing: first word must be 1234ABCD
        exp_addr.push_back(24'h000100);
        pix(16'h1234, 1'b1);
        pix(16'hABCD, 1'b0);
        run(14);
        drain();

        // delayed ack, toggling wr_rdy
        ack_delay  = 4;
        rdy_toggle = 1'b1;
        exp_addr.push_back(24'h000108);
        run(16);
        drain();
        ack_delay  = 0;
        rdy_toggle = 1'b0;

        // odd pixel count, then sof discards the dangling half-word
        exp_addr.push_back(24'h000110);
        run(17);
        drain();
        exp_addr.push_back(24'h000100);
        pix(16'h5A5A, 1'b1);
        run(15);
        drain();

        // frame wrap without sof
        exp_addr.push_back(24'h000108);
        exp_addr.push_back(24'h000110);
        exp_addr.push_back(24'h000118);
        exp_addr.push_back(24'h000100);
        run(64);
        drain();

        // overflow: 40 words while memory stalls, only 32 survive
        exp_addr.push_back(24'h000108);
        exp_addr.push_back(24'h000110);
        exp_addr.push_back(24'h000118);
        exp_addr.push_back(24'h000100);
        rdy_low = 1'b1;
        budget  = 32;
        run(64);
        repeat (3) tick();
        check("ovf_at_32", ovf, 0);
        run(2);
        repeat (3) tick();
        check("ovf_at_33", ovf, 1);
        run(14);
        repeat (3) tick();
        check("ovf_at_40", ovf, 1);
`ifdef PIX_BURST_STAT_EN
        check("drop_cnt_8", drop_cnt, 16'd8);
`endif
        rdy_low = 1'b0;
        budget  = -1;
        drain();
        check("ovf_sticky", ovf, 1);
        exp_addr.push_back(24'h000100);
        pix(16'hC0DE, 1'b1);
        check("ovf_sof_clear", ovf, 0);
`ifdef PIX_BURST_STAT_EN
        check("drop_cnt_clr", drop_cnt, 16'd0);
        check("frame_cnt_3", frame_cnt, 16'd3);
`endif
        run(15);
        drain();

        // reset after 3 of 8 words
        abort_after = 3;
        exp_addr.push_back(24'h000108);
        run(16);
        t = 0;
        while (!abort_hit && t < 500) begin
            tick();
            t++;
        end
        check("abort_reached", abort_hit, 1);
        s_rst = 1'b1;
        tick();
        check("abort_wr_req", wr_req, 0);
        check("abort_wr_addr", wr_addr, BASE);
        check("abort_wr_data", wr_data, 0);
        s_rst       = 1'b0;
        abort_after = 0;
        abort_hit   = 1'b0;
        exp_data.delete();
        exp_addr.delete();
        hv = 1'b0;
        repeat (30) tick();

        // after reset FIFO is empty and address is back at base
        exp_addr.push_back(24'h000100);
        run(16);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
